// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle shared by both requesters and the memory port.
// master drives the address phase and receives the handshakes and read data;
// slave is the opposite side.
interface sram_req_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  req;
   logic                  wr;
   logic [1:0]            size;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_req_arbiter.sv
// Arbiter sharing one SRAM-like memory port between the instruction and data
// requesters. One transaction is in flight at a time; request fields are
// registered so the memory port sees stable values until it accepts them.
// Optional feature: define ARB_RR_EN for round-robin tie breaking
// (default: data wins over inst on a tie).
module sram_req_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   sram_req_arbiter_if.slave    inst_io,
   sram_req_arbiter_if.slave    data_io,
   sram_req_arbiter_if.master   mem_io
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAddr = 2'd1;
   localparam logic [1:0] StData = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                owner_q, owner_d;   // 0 = inst, 1 = data
   logic                wr_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   inst_rdata_q;
   logic [DATA_W-1:0]   data_rdata_q;

   logic grant_inst, grant_data, accept, resp;

`ifdef ARB_RR_EN
   logic last_grant_q;                      // 1 = data was granted last

   // Tie goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      grant_data = data_io.req && (!inst_io.req || !last_grant_q);
      grant_inst = inst_io.req && !grant_data;
   end

   // Remember the most recent grant for the next tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= grant_data;
      end
   end
`else
   // Fixed priority: data over inst.
   always_comb begin
      grant_data = data_io.req;
      grant_inst = inst_io.req && !grant_data;
   end
`endif

   // Handshake qualifiers; reset suppresses every pulse in the reset cycle.
   always_comb begin
      accept = !reset && (state_q == StIdle) && (grant_data || grant_inst);
      resp   = !reset && (state_q == StData) && mem_io.data_ok;
   end

   // Next-state and owner selection.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StAddr;
               owner_d = grant_data;
            end
         end
         StAddr: if (mem_io.addr_ok) state_d = StData;
         StData: if (mem_io.data_ok) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, latched request fields and per-requester read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         wr_q         <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wstrb_q      <= '0;
         wdata_q      <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (accept) begin
            wr_q    <= grant_data ? data_io.wr    : inst_io.wr;
            size_q  <= grant_data ? data_io.size  : inst_io.size;
            addr_q  <= grant_data ? data_io.addr  : inst_io.addr;
            wstrb_q <= grant_data ? data_io.wstrb : inst_io.wstrb;
            wdata_q <= grant_data ? data_io.wdata : inst_io.wdata;
         end
         if (resp && !owner_q) inst_rdata_q <= mem_io.rdata;
         if (resp && owner_q)  data_rdata_q <= mem_io.rdata;
      end
   end

   // Requester handshakes; rdata is live on the response cycle, held otherwise.
   always_comb begin
      inst_io.addr_ok = accept && grant_inst;
      data_io.addr_ok = accept && grant_data;
      inst_io.data_ok = resp && !owner_q;
      data_io.data_ok = resp && owner_q;
      inst_io.rdata   = (resp && !owner_q) ? mem_io.rdata : inst_rdata_q;
      data_io.rdata   = (resp && owner_q)  ? mem_io.rdata : data_rdata_q;
   end

   // Memory port driven purely from registered fields.
   always_comb begin
      mem_io.req   = (state_q == StAddr);
      mem_io.wr    = wr_q;
      mem_io.size  = size_q;
      mem_io.addr  = addr_q;
      mem_io.wstrb = wstrb_q;
      mem_io.wdata = wdata_q;
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized bench for sram_req_arbiter against a transaction-level model.
module tb_sram_req_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic          wr;
      logic [1:0]    size;
      logic [AW-1:0] addr;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_bus ();
   sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_bus ();
   sram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

   sram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .inst_io (inst_bus.slave),
      .data_io (data_bus.slave),
      .mem_io  (mem_bus.master)
   );

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transaction, owner, and
   // whether the memory has taken its address yet.
   bit          busy, issued, owner, last_grant;
   txn_t        cur;
   logic [DW-1:0] last_rd [2];
   txn_t        pend [2];
   bit          have [2];
   bit          force_both, quiet;
   int          grant_log [$];
   int          exp_order [4];

   function automatic txn_t rand_txn();
      txn_t t;
      t.wr    = 1'($urandom_range(0, 1));
      t.size  = 2'($urandom_range(0, 2));
      t.addr  = $urandom;
      t.wstrb = 4'($urandom);
      t.wdata = $urandom;
      return t;
   endfunction

   task automatic model_reset();
      busy = 0; issued = 0; owner = 0; last_grant = 1;
      last_rd[0] = '0; last_rd[1] = '0;
   endtask

   // One clock: drive at negedge, check 1 ns later, advance the model.
   task automatic step(input bit rst, input int unsigned p_aok, input int unsigned p_dok);
      bit g_inst, g_data, rsp, tie_data;
      logic [DW-1:0] mrd;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         if (quiet) have[r] = 0;
         else if (!have[r] && (force_both || $urandom_range(0, 99) < 40)) begin
            pend[r] = rand_txn();
            have[r] = 1;
         end
      end
      reset        = rst;
      inst_bus.req = have[0];
      {inst_bus.wr, inst_bus.size, inst_bus.addr, inst_bus.wstrb, inst_bus.wdata} = pend[0];
      data_bus.req = have[1];
      {data_bus.wr, data_bus.size, data_bus.addr, data_bus.wstrb, data_bus.wdata} = pend[1];
      mem_bus.addr_ok = ($urandom_range(0, 99) < p_aok);
      mem_bus.data_ok = ($urandom_range(0, 99) < p_dok);
      mrd             = $urandom;
      mem_bus.rdata   = mrd;
      #1;
`ifdef ARB_RR_EN
      tie_data = (last_grant == 0);
`else
      tie_data = 1;
`endif
      g_data = !rst && !busy && have[1] && (!have[0] || tie_data);
      g_inst = !rst && !busy && have[0] && !g_data;
      rsp    = !rst && busy && issued && mem_bus.data_ok;

      check_eq("inst_addr_ok", inst_bus.addr_ok, g_inst);
      check_eq("data_addr_ok", data_bus.addr_ok, g_data);
      check_eq("inst_data_ok", inst_bus.data_ok, rsp && !owner);
      check_eq("data_data_ok", data_bus.data_ok, rsp && owner);
      check_eq("inst_rdata", inst_bus.rdata, (rsp && !owner) ? mrd : last_rd[0]);
      check_eq("data_rdata", data_bus.rdata, (rsp && owner) ? mrd : last_rd[1]);
      check_eq("mem_req", mem_bus.req, busy && !issued);
      if (busy && !issued)
         check_eq("mem_fields",
                  {mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wstrb, mem_bus.wdata}, cur);

      if (rst) begin
         model_reset();
      end else begin
         if (rsp) begin
            last_rd[owner] = mrd;
            busy = 0;
         end else if (busy && !issued && mem_bus.addr_ok) begin
            issued = 1;
         end else if (g_data || g_inst) begin
            owner      = g_data;
            last_grant = g_data;
            cur        = pend[g_data];
            have[g_data] = 0;
            busy       = 1;
            issued     = 0;
            grant_log.push_back(int'(g_data));
         end
      end
   endtask

   initial begin
`ifdef ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{1, 1, 1, 1};
`endif
      reset = 1;
      inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 0; inst_bus.addr = 0;
      inst_bus.wstrb = 0; inst_bus.wdata = 0;
      data_bus.req = 0; data_bus.wr = 0; data_bus.size = 0; data_bus.addr = 0;
      data_bus.wstrb = 0; data_bus.wdata = 0;
      mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
      have[0] = 0; have[1] = 0; pend[0] = '0; pend[1] = '0;
      force_both = 0; quiet = 1;
      model_reset();
      repeat (2) @(posedge clk);

      // Reset state, with a stray response present.
      step(1, 0, 100);
      step(0, 0, 100);

      // Both requesters asking continuously from reset.
      quiet = 0; force_both = 1;
      for (int c = 0; c < 200 && grant_log.size() < 4; c++) step(0, 100, 100);
      check_eq("grant_count", grant_log.size(), 4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check_eq($sformatf("grant_order%0d", i), grant_log[i], exp_order[i]);
      force_both = 0;
      while (busy) step(0, 100, 100);

      // Directed instruction fetch.
      quiet = 1;
      step(0, 0, 0);
      quiet = 0; have[1] = 0;
      pend[0] = '{wr: 1'b0, size: 2'd2, addr: 32'hBFC0_0000, wstrb: 4'hF, wdata: 32'h0};
      have[0] = 1;
      for (int c = 0; c < 20 && (busy || have[0]); c++) step(0, 100, 50);

      // Randomized traffic with occasional reset and long address stalls.
      for (int blk = 0; blk < 30; blk++) begin
         int unsigned pa;
         pa = (blk % 3 == 0) ? 10 : $urandom_range(30, 100);
         for (int k = 0; k < 100; k++) step($urandom_range(0, 199) == 0, pa, 30);
      end

      // Reset while waiting for the response, then stray responses in idle.
      quiet = 0;
      for (int c = 0; c < 200 && !(busy && issued); c++) step(0, 100, 0);
      check_eq("reached_data", busy && issued, 1);
      step(1, 100, 100);
      quiet = 1;
      repeat (6) step(0, 100, 100);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
